msrv32_integer_file: RTL
========================

# msrv32_integer_file

Architectural integer register file (x0–x31) of the msrv32 core. It sits directly downstream of `msrv32_wb_mux_sel_unit`: it takes the selected writeback value `wb_mux_out` plus the destination address and write enable from pipeline stage 3, and stores it. It serves two combinational read ports to the decode/operand stage. Read-after-write hazards in the same cycle are resolved with an internal write-through bypass.

## Interface
Parameters:
- `XLEN`, 32, data width of each register.
- `NREGS`, 32, number of architectural registers; address width is log2(NREGS) = 5.

Ports:
- `ms_riscv32_mp_clk_in`  input  1  core clock; all state updates occur on its rising edge.
- `ms_riscv32_mp_rst_in`  input  1  reset; synchronous, active-high.
- `rs_1_addr_in`  input  5  source register 1 address.
- `rs_2_addr_in`  input  5  source register 2 address.
- `rd_addr_in`  input  5  destination register address, from the stage-3 pipeline register.
- `wr_en_in`  input  1  write enable, already qualified by the control unit (flush or trap removes it).
- `rd_in`  input  XLEN  write data; this is `wb_mux_out`.
- `rs_1_out`  output  XLEN  source 1 operand.
- `rs_2_out`  output  XLEN  source 2 operand.

## Operation
- Storage is registers x1..x31, XLEN bits each.
- x0 has no storage. Any read of address 0 returns 0.
- **Write:** on a rising edge, if `wr_en_in`=1 and `rd_addr_in`≠0 and reset is low, then `reg[rd_addr_in]` ← `rd_in`.
  - A write with `rd_addr_in`=0 is discarded with no side effect.
- **Read:** each port is independent and combinational.
  - Port n returns 0 if its address is 0.
  - Otherwise it returns `rd_in` if `wr_en_in`=1 and `rd_addr_in` equals the port address (bypass).
  - Otherwise it returns `reg[addr]`.
- Both ports may address the same register. Both then return an identical value, including during bypass.
- **Reset:**
  - While `ms_riscv32_mp_rst_in`=1, `rs_1_out` and `rs_2_out` are forced to 0.
  - Bypass is suppressed and writes are ignored.
  - On the rising edge with reset high, all of x1..x31 are cleared to 0 in that single cycle.
- Reset asserted in the middle of a write stream: the edge with reset high clears the registers and drops that cycle's write. The first write accepted is on the first edge after reset deasserts.
- No X propagation: every register has a defined value after one reset edge.

## Timing
- Write latency: data is committed at edge N and is visible from stored state after edge N. Through the bypass it is visible combinationally in the same cycle N.
- Read latency: 0 cycles. `rs_*_out` is a purely combinational function of the addresses, the write-port inputs, the reset input and the state.
- Reset values: `rs_1_out` = `rs_2_out` = 0 during reset. All stored registers are 0 after the reset edge.
- Back-to-back writes to the same register on consecutive cycles: the last write wins. Reads in each cycle see that cycle's write via the bypass.
- Critical path: `rd_in` → bypass mux → `rs_*_out`. This is one 2:1 mux after the 32:1 read mux, and the read mux is the only deep logic.

## Structure
- Shared package `msrv32_pkg` holds:
  - `XLEN` and `REG_ADDR_W` (5);
  - `X0_ADDR` (5'd0);
  - the WB select encodings (`WB_ALU`=000, `WB_LU`=001, `WB_IMM`=010, `WB_IADDER_OUT`=011, `WB_CSR`=100, `WB_PC_PLUS`=101), which are shared with `msrv32_wb_mux_sel_unit`.
- One sub-module is natural: `msrv32_reg_read_port`.
  - Contains the address decode, the x0 zeroing, the bypass compare and the reset forcing.
  - It is instantiated twice.
- The storage array and write logic stay in the top module.

## Test plan
1. **Reset clears state.** Stimulus: hold reset 2 cycles after first writing x5=0xDEADBEEF. Required response: `rs_1_out`=0 during reset; reading x5 after reset returns 0x00000000.
2. **Basic write and read.** Stimulus: write x1=0xAAAAAAAA, x31=0x55555555 on consecutive edges, then read rs1=1, rs2=31. Required response: `rs_1_out`=0xAAAAAAAA, `rs_2_out`=0x55555555.
3. **x0 immutable.** Stimulus: `wr_en_in`=1, `rd_addr_in`=0, `rd_in`=0xFFFFFFFF, then read rs1=rs2=0. Required response: both outputs are 0. Bypass also does not fire in the write cycle.
4. **Same-cycle bypass.** Stimulus: x7 holds 0x11111111; in one cycle set `wr_en_in`=1, `rd_addr_in`=7, `rd_in`=0x22222222, rs1=rs2=7. Required response: both outputs are 0x22222222 in that cycle and remain 0x22222222 after the edge.
5. **Write enable low.** Stimulus: `wr_en_in`=0, `rd_addr_in`=9, `rd_in`=0x12345678 with x9 = 0xCAFEF00D. Required response: rs1=9 returns 0xCAFEF00D before and after the edge.
6. **Reset during write.** Stimulus: on the edge with reset=1, present `wr_en_in`=1, `rd_addr_in`=3, `rd_in`=0x0F0F0F0F. Required response: x3=0 after the edge; a retry with reset=0 reads back 0x0F0F0F0F.

Source files
------------

// File: rtl/msrv32_pkg.sv
// msrv32 shared definitions: data width, register addressing and the
// writeback select encodings shared with the writeback mux.
package msrv32_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] X0_ADDR = 5'd0;

   typedef enum logic [2:0] {
      WB_ALU        = 3'b000,
      WB_LU         = 3'b001,
      WB_IMM        = 3'b010,
      WB_IADDER_OUT = 3'b011,
      WB_CSR        = 3'b100,
      WB_PC_PLUS    = 3'b101
   } wb_sel_e;

endpackage

// File: rtl/msrv32_integer_file_if.sv
// Register file access bundle: two read ports and the writeback port.
interface msrv32_integer_file_if
   import msrv32_pkg::*;
   #(parameter int XLEN_P = XLEN);

   logic [REG_ADDR_W-1:0] rs_1_addr;
   logic [REG_ADDR_W-1:0] rs_2_addr;
   logic [REG_ADDR_W-1:0] rd_addr;
   logic                  wr_en;
   logic [XLEN_P-1:0]     rd;
   logic [XLEN_P-1:0]     rs_1;
   logic [XLEN_P-1:0]     rs_2;

   modport master (
      output rs_1_addr, rs_2_addr, rd_addr, wr_en, rd,
      input  rs_1, rs_2
   );

   modport slave (
      input  rs_1_addr, rs_2_addr, rd_addr, wr_en, rd,
      output rs_1, rs_2
   );

endinterface

// File: rtl/msrv32_reg_read_port.sv
// One combinational read port: x0 zeroing, reset forcing,
// write-through bypass, then the 32:1 read mux.
module msrv32_reg_read_port
   import msrv32_pkg::*;
   #(
      parameter int XLEN_P = XLEN,
      parameter int NREGS  = 32,
      localparam int AW    = $clog2(NREGS)
   ) (
      input  logic                         rst,
      input  logic [AW-1:0]                addr,
      input  logic [AW-1:0]                rd_addr,
      input  logic                         wr_en,
      input  logic [XLEN_P-1:0]            rd_in,
      input  logic [NREGS-1:0][XLEN_P-1:0] regs,
      output logic [XLEN_P-1:0]            data
   );

   logic is_x0;
   logic hit;

   assign is_x0 = (addr == AW'(X0_ADDR));
   assign hit   = wr_en && (rd_addr == addr);

   // Bypass sits after the array mux so rd_in sees only one 2:1 stage.
   always_comb begin
      data = '0;
      if (rst || is_x0)
         data = '0;
      else if (hit)
         data = rd_in;
      else
         data = regs[addr];
   end

endmodule

// File: rtl/msrv32_integer_file.sv
// msrv32 architectural integer register file x1..x31 with two
// bypassed combinational read ports; x0 is hardwired to zero.
module msrv32_integer_file
   import msrv32_pkg::*;
   #(
      parameter int XLEN  = msrv32_pkg::XLEN,
      parameter int NREGS = 32,
      localparam int AW   = $clog2(NREGS)
   ) (
      input  logic            ms_riscv32_mp_clk_in,
      input  logic            ms_riscv32_mp_rst_in,
      input  logic [AW-1:0]   rs_1_addr_in,
      input  logic [AW-1:0]   rs_2_addr_in,
      input  logic [AW-1:0]   rd_addr_in,
      input  logic            wr_en_in,
      input  logic [XLEN-1:0] rd_in,
      output logic [XLEN-1:0] rs_1_out,
      output logic [XLEN-1:0] rs_2_out
   );

   logic [NREGS-1:1][XLEN-1:0] regs;
   logic [NREGS-1:0][XLEN-1:0] regs_view;
   logic                       wr_ok;

   assign wr_ok = wr_en_in && (rd_addr_in != AW'(X0_ADDR));

   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (ms_riscv32_mp_rst_in)
         regs <= '0;
      else if (wr_ok)
         regs[rd_addr_in] <= rd_in;
   end

   // Slot 0 is a constant, not storage; ports zero it anyway.
   assign regs_view = {regs, {XLEN{1'b0}}};

   msrv32_reg_read_port #(.XLEN_P(XLEN), .NREGS(NREGS)) u_rp1 (
      .rst     (ms_riscv32_mp_rst_in),
      .addr    (rs_1_addr_in),
      .rd_addr (rd_addr_in),
      .wr_en   (wr_en_in),
      .rd_in   (rd_in),
      .regs    (regs_view),
      .data    (rs_1_out)
   );

   msrv32_reg_read_port #(.XLEN_P(XLEN), .NREGS(NREGS)) u_rp2 (
      .rst     (ms_riscv32_mp_rst_in),
      .addr    (rs_2_addr_in),
      .rd_addr (rd_addr_in),
      .wr_en   (wr_en_in),
      .rd_in   (rd_in),
      .regs    (regs_view),
      .data    (rs_2_out)
   );

endmodule
